gate_resp_checker: RTL and testbench
====================================

Name: gate_resp_checker

Overview:
- Synthesizable response checker: the observing end of a 2-input gate test loop, paired with a stimulus source that toggles the gate inputs.
- Accepts (a, b, y) samples over a valid/ready handshake and compares y against the expected output of a selected 2-input function.
- Counts passes and failures, tracks truth-table coverage of the 4 input combinations, and logs mismatching samples in a small FIFO.
- Sits beside the gate under test and reports a pass/fail verdict once all 4 input combinations have been seen.

Parameters:
- CNT_W, 8, width of the pass and fail counters (saturating).
- ERR_DEPTH, 4, depth of the mismatch log FIFO (power of 2, at least 2).

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  2  expected function: 0 NAND, 1 AND, 2 OR, 3 XOR. Latched on start.
- start  in  1  one-cycle pulse that begins a check run.
- in_valid  in  1  a sample is present on a, b, y.
- in_ready  out  1  checker accepts a sample this cycle.
- a  in  1  gate input A.
- b  in  1  gate input B.
- y  in  1  observed gate output.
- busy  out  1  a run is in progress (state RUN).
- done  out  1  run complete (state DONE).
- pass  out  1  done and fail_cnt == 0.
- coverage  out  4  bit {a,b} set once that combination has been sampled.
- pass_cnt  out  CNT_W  number of matching samples.
- fail_cnt  out  CNT_W  number of mismatching samples.
- err_valid  out  1  mismatch log is not empty.
- err_pop  in  1  consume the head entry of the log when err_valid.
- err_data  out  3  head entry {a,b,y}.
- err_ovf  out  1  sticky: a mismatch was dropped because the log was full.

Behaviour:
- Reset: state IDLE. in_ready, busy, done, pass, err_valid, err_ovf = 0. coverage, pass_cnt, fail_cnt, err_data = 0. Log emptied. Latched op = 0.
- States:
  - IDLE: start -> RUN.
  - RUN: start is ignored. The accept that completes coverage (coverage | onehot({a,b}) == 4'hF) -> DONE on the next edge.
  - DONE: start -> RUN (restart).
  - No other transitions.
- Start (IDLE or DONE), single edge: latch op; clear coverage, both counters, log contents and err_ovf.
- in_ready = (state == RUN), combinational from state. A sample is accepted when in_valid && in_ready.
- Expected value = f(op_q, a, b). Accepted samples update counters and coverage on the same edge, so results are visible the next cycle (latency 1).
- Match: pass_cnt += 1. Mismatch: fail_cnt += 1 and {a,b,y} is pushed to the log.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Log full + mismatch + err_pop in the same cycle: pop and push both occur; no overflow.
- Log full + mismatch, no pop: entry dropped, err_ovf set; fail_cnt still increments.
- err_pop when empty: no effect.
- err_data holds the head entry whenever err_valid = 1; it is 0 when the log is empty.
- The log may be popped in any state, including during RUN.
- Samples with in_valid high outside RUN are not accepted and have no effect.
- Repeat combinations: counted every time; coverage is unaffected.
- rst asserted mid-run: returns to the reset state on that edge and discards the run.
- Changes to op after start have no effect until the next start.

Decomposition:
- Package gate_chk_pkg:
  - op encodings OP_NAND = 0, OP_AND = 1, OP_OR = 2, OP_XOR = 3;
  - state enum {IDLE, RUN, DONE};
  - function exp_out(op, a, b).
- Sub-module err_fifo: synchronous FIFO, width 3, depth ERR_DEPTH, with push, pop, full, empty and head data; pop-and-push when full is legal.

Test Plan:
- NAND, correct gate: start with op = 0; feed (0,0,1), (1,0,1), (0,1,1), (1,1,0), one per cycle with in_valid held high -> done = 1 the cycle after the 4th accept; pass = 1, pass_cnt = 4, fail_cnt = 0, coverage = 4'hF, err_valid = 0.
- Faulty gate: op = 0; feed (1,1,1), then the remaining 3 combinations correct -> fail_cnt = 1, pass_cnt = 3, pass = 0; err_valid = 1 with err_data = 3'b111; one err_pop -> err_valid = 0.
- Log overflow: ERR_DEPTH = 4, op = 1 (AND); feed 6 mismatching (0,0,1) samples -> fail_cnt = 6, err_ovf = 1, log holds 4 entries, coverage = 4'b0001, state still RUN. Variant: pop on the 5th push cycle -> no overflow from that push.
- Backpressure and ignored start: in_valid high while IDLE -> in_ready = 0, counters stay 0. start pulse during RUN -> counters are not cleared.
- Saturation: CNT_W = 2, op = 3 (XOR); feed 5 correct (0,0,0) samples -> pass_cnt = 3, state stays RUN.
- Reset mid-run: after 2 accepts assert rst for 1 cycle -> all outputs return to 0 and state is IDLE. Restart from DONE clears coverage and counters to 0 on the start edge.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: op encodings, checker states and expected-output function
package gate_chk_pkg;
  localparam logic [1:0] OP_NAND = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_OR   = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic exp_out(input logic [1:0] op, input logic a, input logic b);
    return op == OP_NAND ? !(a & b) : op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ b;
  endfunction
endpackage

// File: rtl/gate_resp_checker_err_fifo.sv
// err_fifo: 3-bit synchronous mismatch log with simultaneous pop/push when full
module err_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic       full,
  output logic       empty,
  output logic [2:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_pop, do_push;
  assign empty   = wp == rp;
  assign full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 3'd0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: checks (a,b,y) samples against a 2-input function, with counters, coverage and mismatch log
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ERR_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       coverage,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_valid,
  input  logic             err_pop,
  output logic [2:0]       err_data,
  output logic             err_ovf
);
  state_t state, nxt;
  logic [1:0] op_q;
  logic [3:0] cov_nxt;
  logic acc, match, go, full, empty;
  assign in_ready  = state == RUN;
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign pass      = done && fail_cnt == '0;
  assign acc       = in_valid && in_ready;
  assign match     = y == exp_out(op_q, a, b);
  assign go        = start && state != RUN;
  assign cov_nxt   = coverage | (4'b1 << {a, b});
  assign err_valid = !empty;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? RUN : IDLE)
        : state == RUN  ? (acc && cov_nxt == 4'hF ? DONE : RUN)
        : (start ? RUN : DONE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NAND;
      coverage <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_ovf  <= 1'b0;
    end else if (go) begin
      op_q     <= op;
      coverage <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err_ovf  <= 1'b0;
    end else if (acc) begin
      coverage <= cov_nxt;
      if (match) pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
      else begin
        fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
        if (full && !err_pop) err_ovf <= 1'b1;
      end
    end
  end
  err_fifo #(.DEPTH(ERR_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clr(go), .push(acc && !match), .pop(err_pop),
    .din({a, b, y}), .full(full), .empty(empty), .dout(err_data)
  );
endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: directed scenario tests for gate_resp_checker
module tb_gate_resp_checker;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, a = 0, b = 0, y = 0, err_pop = 0;
  logic [1:0] op = 0;
  logic in_ready, busy, done, pass, err_valid, err_ovf;
  logic [3:0] coverage;
  logic [7:0] pass_cnt, fail_cnt;
  logic [2:0] err_data;
  logic in_ready2, busy2, done2, pass2, err_valid2, err_ovf2;
  logic [3:0] coverage2;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic [2:0] err_data2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gate_resp_checker dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass), .coverage(coverage),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_valid(err_valid), .err_pop(err_pop),
    .err_data(err_data), .err_ovf(err_ovf)
  );
  gate_resp_checker #(.CNT_W(2), .ERR_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .op(op), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .y(y), .busy(busy2), .done(done2), .pass(pass2), .coverage(coverage2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .err_valid(err_valid2), .err_pop(err_pop),
    .err_data(err_data2), .err_ovf(err_ovf2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [1:0] o);
    op = o; start = 1; tick; start = 0;
  endtask
  task automatic feed(input logic [2:0] s);
    {a, b, y} = s; in_valid = 1; tick; in_valid = 0;
  endtask
  task automatic test_reset;
    rst = 1; tick; rst = 0;
    total++; if ({in_ready, busy, done, pass, err_valid, err_ovf} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b want=000000", {in_ready, busy, done, pass, err_valid, err_ovf}); end
    total++; if ({coverage, pass_cnt, fail_cnt, err_data} !== 23'b0) begin bad++; $display("FAIL reset_data cov=%h pc=%0d fc=%0d ed=%b want 0", coverage, pass_cnt, fail_cnt, err_data); end
  endtask
  task automatic test_nand_pass;
    do_start(0);
    total++; if (busy !== 1 || in_ready !== 1) begin bad++; $display("FAIL nand_busy busy=%b rdy=%b want 1 1", busy, in_ready); end
    feed(3'b001); feed(3'b101);
    total++; if (pass_cnt !== 2 || coverage !== 4'b0101) begin bad++; $display("FAIL nand_mid pc=%0d cov=%b want 2 0101", pass_cnt, coverage); end
    feed(3'b011);
    total++; if (done !== 0) begin bad++; $display("FAIL nand_not_done done=%b want 0", done); end
    feed(3'b110);
    total++; if (done !== 1 || pass !== 1 || busy !== 0) begin bad++; $display("FAIL nand_done done=%b pass=%b busy=%b want 1 1 0", done, pass, busy); end
    total++; if (pass_cnt !== 4 || fail_cnt !== 0 || coverage !== 4'hF || err_valid !== 0) begin bad++; $display("FAIL nand_cnt pc=%0d fc=%0d cov=%h ev=%b want 4 0 f 0", pass_cnt, fail_cnt, coverage, err_valid); end
  endtask
  task automatic test_faulty;
    do_start(0);
    feed(3'b111); feed(3'b001); feed(3'b011); feed(3'b101);
    total++; if (pass_cnt !== 3 || fail_cnt !== 1 || pass !== 0 || done !== 1) begin bad++; $display("FAIL faulty_cnt pc=%0d fc=%0d pass=%b done=%b want 3 1 0 1", pass_cnt, fail_cnt, pass, done); end
    total++; if (err_valid !== 1 || err_data !== 3'b111) begin bad++; $display("FAIL faulty_log ev=%b ed=%b want 1 111", err_valid, err_data); end
    err_pop = 1; tick; err_pop = 0;
    total++; if (err_valid !== 0 || err_data !== 0) begin bad++; $display("FAIL faulty_pop ev=%b ed=%b want 0 000", err_valid, err_data); end
  endtask
  task automatic test_overflow;
    do_start(1);
    repeat (6) feed(3'b001);
    total++; if (fail_cnt !== 6 || err_ovf !== 1 || coverage !== 4'b0001 || busy !== 1) begin bad++; $display("FAIL ovf_state fc=%0d ovf=%b cov=%b busy=%b want 6 1 0001 1", fail_cnt, err_ovf, coverage, busy); end
    feed(3'b010); feed(3'b100); feed(3'b111);
    total++; if (done !== 1 || pass_cnt !== 3) begin bad++; $display("FAIL ovf_finish done=%b pc=%0d want 1 3", done, pass_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (err_valid !== 1 || err_data !== 3'b001) begin bad++; $display("FAIL ovf_entry%0d ev=%b ed=%b want 1 001", i, err_valid, err_data); end
      err_pop = 1; tick; err_pop = 0;
    end
    total++; if (err_valid !== 0) begin bad++; $display("FAIL ovf_drained ev=%b want 0", err_valid); end
    do_start(1);
    total++; if (pass_cnt !== 0 || fail_cnt !== 0 || coverage !== 0 || err_ovf !== 0 || busy !== 1) begin bad++; $display("FAIL restart_clear pc=%0d fc=%0d cov=%b ovf=%b busy=%b want 0 0 0 0 1", pass_cnt, fail_cnt, coverage, err_ovf, busy); end
    repeat (4) feed(3'b001);
    err_pop = 1; feed(3'b011); err_pop = 0;
    total++; if (err_ovf !== 0 || fail_cnt !== 5 || err_data !== 3'b001) begin bad++; $display("FAIL ovf_poppush ovf=%b fc=%0d ed=%b want 0 5 001", err_ovf, fail_cnt, err_data); end
    for (int i = 0; i < 3; i++) begin err_pop = 1; tick; end
    err_pop = 0;
    total++; if (err_valid !== 1 || err_data !== 3'b011) begin bad++; $display("FAIL ovf_tail ev=%b ed=%b want 1 011", err_valid, err_data); end
    feed(3'b100); feed(3'b111);
    total++; if (done !== 1) begin bad++; $display("FAIL ovf_done2 done=%b want 1", done); end
  endtask
  task automatic test_backpressure;
    test_reset;
    {a, b, y} = 3'b001; in_valid = 1;
    #1;
    total++; if (in_ready !== 0) begin bad++; $display("FAIL bp_ready rdy=%b want 0", in_ready); end
    tick; tick; in_valid = 0;
    total++; if (pass_cnt !== 0 || fail_cnt !== 0 || coverage !== 0 || busy !== 0) begin bad++; $display("FAIL bp_idle pc=%0d fc=%0d cov=%b busy=%b want 0 0 0 0", pass_cnt, fail_cnt, coverage, busy); end
    do_start(0);
    feed(3'b001);
    do_start(3);
    total++; if (pass_cnt !== 1 || busy !== 1 || coverage !== 4'b0001) begin bad++; $display("FAIL bp_ignore_start pc=%0d busy=%b cov=%b want 1 1 0001", pass_cnt, busy, coverage); end
    feed(3'b110);
    total++; if (pass_cnt !== 2 || fail_cnt !== 0) begin bad++; $display("FAIL bp_op_kept pc=%0d fc=%0d want 2 0", pass_cnt, fail_cnt); end
  endtask
  task automatic test_reset_mid_run;
    rst = 1; tick; rst = 0;
    total++; if ({busy, done, pass, in_ready, err_valid, err_ovf, coverage, pass_cnt, fail_cnt} !== 26'b0) begin bad++; $display("FAIL midrst busy=%b done=%b cov=%b pc=%0d fc=%0d want all 0", busy, done, coverage, pass_cnt, fail_cnt); end
    feed(3'b001);
    total++; if (pass_cnt !== 0 || busy !== 0) begin bad++; $display("FAIL midrst_idle pc=%0d busy=%b want 0 0", pass_cnt, busy); end
  endtask
  task automatic test_saturation;
    do_start(3);
    repeat (5) feed(3'b000);
    total++; if (pass_cnt2 !== 2'd3 || busy2 !== 1) begin bad++; $display("FAIL sat_pass pc=%0d busy=%b want 3 1", pass_cnt2, busy2); end
    total++; if (pass_cnt !== 5) begin bad++; $display("FAIL sat_wide pc=%0d want 5", pass_cnt); end
    repeat (4) feed(3'b001);
    total++; if (fail_cnt2 !== 2'd3 || err_ovf2 !== 0 || fail_cnt !== 4) begin bad++; $display("FAIL sat_fail fc2=%0d ovf2=%b fc=%0d want 3 0 4", fail_cnt2, err_ovf2, fail_cnt); end
  endtask
  initial begin
    #2;
    test_reset;
    test_nand_pass;
    test_faulty;
    test_overflow;
    test_backpressure;
    test_reset_mid_run;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
